move_commit: RTL and testbench

MOVE_COMMIT -- requirements
Module: move_commit

---
 rtl/move_commit_if.sv | 47 ++++
 rtl/move_commit.sv | 145 ++++++++++++++
 tb/tb_move_commit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_commit_if.sv
// rtl/move_commit_if.sv - move/result handshake and board view shared by move_commit and its environment
interface move_commit_if #(
  parameter int N_ROW = 15,
  parameter int N_COL = 15
);
  logic                       i_new_game;
  logic                       i_move_valid;
  logic                       o_move_ready;
  logic [3:0]                 i_row;
  logic [3:0]                 i_col;
  logic                       i_result_ready;
  logic                       i_win;
  logic [2*N_ROW*N_COL-1:0]   o_board;
  logic                       o_turn;
  logic                       o_result_valid;
  logic [1:0]                 o_result;
  logic                       o_game_over;
  logic                       o_winner;
  logic [7:0]                 o_move_count;
`ifdef MOVE_COMMIT_UNDO_EN
  logic                       i_undo;

  modport slave (
    input  i_new_game, i_move_valid, i_row, i_col, i_result_ready, i_win, i_undo,
    output o_move_ready, o_board, o_turn, o_result_valid, o_result, o_game_over,
           o_winner, o_move_count
  );

  modport master (
    output i_new_game, i_move_valid, i_row, i_col, i_result_ready, i_win, i_undo,
    input  o_move_ready, o_board, o_turn, o_result_valid, o_result, o_game_over,
           o_winner, o_move_count
  );
`else
  modport slave (
    input  i_new_game, i_move_valid, i_row, i_col, i_result_ready, i_win,
    output o_move_ready, o_board, o_turn, o_result_valid, o_result, o_game_over,
           o_winner, o_move_count
  );

  modport master (
    output i_new_game, i_move_valid, i_row, i_col, i_result_ready, i_win,
    input  o_move_ready, o_board, o_turn, o_result_valid, o_result, o_game_over,
           o_winner, o_move_count
  );
`endif
endinterface

// File: rtl/move_commit.sv
// rtl/move_commit.sv - gomoku move commit FSM (IDLE/CHECK/RESP); optional one-level undo via MOVE_COMMIT_UNDO_EN
module move_commit #(
  parameter int N_ROW = 15,
  parameter int N_COL = 15
) (
  input logic          i_clk,
  input logic          i_rst,
  move_commit_if.slave bus
);
  localparam int N_CELLS = N_ROW * N_COL;
  localparam int IDXW    = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  localparam logic [1:0] EMPTY       = 2'd2;
  localparam logic [1:0] RES_OK      = 2'd0;
  localparam logic [1:0] RES_ILLEGAL = 2'd1;
  localparam logic [1:0] RES_WIN     = 2'd2;
  localparam logic [1:0] RES_DRAW    = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t          state_q;
  logic [1:0]      cells [N_CELLS];
  logic            ready_q;
  logic            turn_q;
  logic [7:0]      count_q;
  logic            over_q;
  logic            winner_q;
  logic [1:0]      result_q;
  logic            valid_q;

  logic            in_range;
  logic [IDXW-1:0] idx;
  logic            legal;

`ifdef MOVE_COMMIT_UNDO_EN
  logic [IDXW-1:0] last_idx_q;
  logic            last_ok_q;
`endif

  // Decode the requested cell and decide legality against the current board
  always_comb begin
    in_range = (int'(bus.i_row) < N_ROW) && (int'(bus.i_col) < N_COL);
    idx      = IDXW'(int'(bus.i_row) * N_COL + int'(bus.i_col));
    legal    = in_range && !over_q && (cells[idx] == EMPTY);
  end

  // Game state, board and result registers; reset and new game override everything
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_new_game) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      for (int k = 0; k < N_CELLS; k++) cells[k] <= EMPTY;
      turn_q  <= 1'b0;
      count_q <= 8'd0;
      over_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef MOVE_COMMIT_UNDO_EN
      last_ok_q <= 1'b0;
`endif
      if (i_rst) begin
        winner_q <= 1'b0;
        result_q <= RES_OK;
      end
    end else begin
      case (state_q)
        IDLE: begin
`ifdef MOVE_COMMIT_UNDO_EN
          if (bus.i_undo) begin
            // Undo only has one level of history; a repeat undo is refused
            if (last_ok_q) begin
              cells[last_idx_q] <= EMPTY;
              count_q           <= count_q - 8'd1;
              turn_q            <= cells[last_idx_q][0];
              over_q            <= 1'b0;
              last_ok_q         <= 1'b0;
              result_q          <= RES_OK;
            end else begin
              result_q <= RES_ILLEGAL;
            end
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= RESP;
          end else
`endif
          if (bus.i_move_valid) begin
            ready_q <= 1'b0;
            if (legal) begin
              cells[idx] <= {1'b0, turn_q};
              count_q    <= count_q + 8'd1;
              state_q    <= CHECK;
`ifdef MOVE_COMMIT_UNDO_EN
              last_idx_q <= idx;
              last_ok_q  <= 1'b1;
`endif
            end else begin
              result_q <= RES_ILLEGAL;
              valid_q  <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        CHECK: begin
          // Win checker now sees the new stone with the mover's colour selected
          if (bus.i_win) begin
            result_q <= RES_WIN;
            over_q   <= 1'b1;
            winner_q <= turn_q;
          end else if (count_q == 8'(N_CELLS)) begin
            result_q <= RES_DRAW;
            over_q   <= 1'b1;
          end else begin
            result_q <= RES_OK;
            turn_q   <= ~turn_q;
          end
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (bus.i_result_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CELLS; g++) begin : g_board
    assign bus.o_board[2*g +: 2] = cells[g];
  end

  assign bus.o_move_ready   = ready_q;
  assign bus.o_turn         = turn_q;
  assign bus.o_move_count   = count_q;
  assign bus.o_game_over    = over_q;
  assign bus.o_winner       = winner_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = valid_q;
endmodule

// File: tb/tb_move_commit.sv
// tb/tb_move_commit.sv - scoreboard bench for move_commit with a board-level reference model
module tb_move_commit;
  localparam int NR    = 15;
  localparam int NC    = 15;
  localparam int NCELL = NR * NC;
  localparam int BW    = 2 * NCELL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   win_en = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_res = 0;
  bit   prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  move_commit_if #(.N_ROW(NR), .N_COL(NC)) bus();
  move_commit #(.N_ROW(NR), .N_COL(NC)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

  function automatic bit five(input logic [BW-1:0] b, input logic c);
    int n, rr, cc, dr, dc;
    for (int r = 0; r < NR; r++)
      for (int q = 0; q < NC; q++)
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          n = 0;
          for (int k = 0; k < 5; k++) begin
            rr = r + k * dr;
            cc = q + k * dc;
            if (rr < NR && cc >= 0 && cc < NC)
              if (b[2*(rr*NC+cc) +: 2] == {1'b0, c}) n++;
          end
          if (n == 5) return 1'b1;
        end
    return 1'b0;
  endfunction

  assign bus.i_win = win_en && five(bus.o_board, bus.o_turn);

  typedef struct {
    int            res;
    int            cnt;
    int            turn;
    int            over;
    int            winner;
    logic [BW-1:0] board;
    int            acc;
    int            lat;
  } exp_t;
  exp_t sb[$];

  logic [BW-1:0] mb;
  logic mturn, m_over, mwin, m_last_col, m_last_ok;
  int   mcnt, m_last;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_board(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mb = {NCELL{2'b10}};
    mturn = 1'b0; m_over = 1'b0; mcnt = 0; m_last_ok = 1'b0;
  endtask

  function automatic exp_t snap(input int res, input int lat);
    exp_t e;
    e.res = res; e.cnt = mcnt; e.turn = int'(mturn); e.over = int'(m_over);
    e.winner = int'(mwin); e.board = mb; e.acc = cyc; e.lat = lat;
    return e;
  endfunction

  // Result monitor: pops one expectation per rising o_result_valid
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_result_valid && !prev_v) begin
        if (sb.size() == 0) chk("sb_underflow", 0, 1);
        else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          chk("result", bus.o_result, e.res);
          chk("count", bus.o_move_count, e.cnt);
          chk("turn", bus.o_turn, e.turn);
          chk("game_over", bus.o_game_over, e.over);
          if (e.res == 2) chk("winner", bus.o_winner, e.winner);
          chk_board("board", bus.o_board, e.board);
        end
        last_res = int'(bus.o_result);
      end
      prev_v = bus.o_result_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_move_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.o_move_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic drive_move(input int r, input int c);
    int res, lat, i;
    wait_ready();
    @(negedge clk);
    if (r >= NR || c >= NC || m_over) begin res = 1; lat = 1; end
    else if (mb[2*(r*NC+c) +: 2] != 2'b10) begin res = 1; lat = 1; end
    else begin
      i = r * NC + c;
      mb[2*i +: 2] = {1'b0, mturn};
      mcnt++;
      m_last = i; m_last_col = mturn; m_last_ok = 1'b1;
      lat = 2;
      if (win_en && five(mb, mturn)) begin res = 2; m_over = 1'b1; mwin = mturn; end
      else if (mcnt == NCELL) begin res = 3; m_over = 1'b1; end
      else begin res = 0; mturn = ~mturn; end
    end
    sb.push_back(snap(res, lat));
    bus.i_row = 4'(r); bus.i_col = 4'(c);
    bus.i_move_valid = 1'b1;
    bus.i_result_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.i_move_valid = 1'b0;
    bus.i_result_ready = 1'b0;
  endtask

  task automatic finish_resp(input int hold);
    int n = 0;
    while (!bus.o_result_valid && n < 8) begin @(negedge clk); n++; end
    chk("resp_timeout", bus.o_result_valid, 1);
    for (int h = 0; h < hold; h++) begin
      bus.i_move_valid = 1'($urandom_range(0, 1));
      bus.i_row = 4'($urandom_range(0, 7));
      bus.i_col = 4'($urandom_range(0, 7));
      @(negedge clk);
      chk("hold_valid", bus.o_result_valid, 1);
      chk("hold_ready", bus.o_move_ready, 0);
    end
    bus.i_move_valid = 1'b0;
    bus.i_result_ready = 1'b1;
    @(negedge clk);
    bus.i_result_ready = 1'b0;
    chk("release_valid", bus.o_result_valid, 0);
    chk("release_ready", bus.o_move_ready, 1);
  endtask

  task automatic issue(input int r, input int c, input int hold);
    drive_move(r, c);
    finish_resp(hold);
  endtask

  task automatic new_game();
    @(negedge clk);
    bus.i_new_game = 1'b1;
    @(negedge clk);
    bus.i_new_game = 1'b0;
    model_clear();
    chk_board("newgame_board", bus.o_board, mb);
    chk("newgame_count", bus.o_move_count, 0);
    chk("newgame_turn", bus.o_turn, 0);
  endtask

`ifdef MOVE_COMMIT_UNDO_EN
  task automatic drive_undo();
    int res;
    wait_ready();
    @(negedge clk);
    if (m_last_ok) begin
      mb[2*m_last +: 2] = 2'b10;
      mcnt--; mturn = m_last_col; m_over = 1'b0; m_last_ok = 1'b0; res = 0;
    end else res = 1;
    sb.push_back(snap(res, 1));
    bus.i_undo = 1'b1;
    bus.i_move_valid = 1'b1;
    bus.i_row = 4'd9; bus.i_col = 4'd9;
    @(negedge clk);
    bus.i_undo = 1'b0;
    bus.i_move_valid = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal;
  end

  initial begin
    int order[NCELL];
    int t, j, r, c, sel;
    bus.i_new_game = 1'b0; bus.i_move_valid = 1'b0; bus.i_result_ready = 1'b0;
    bus.i_row = 4'd0; bus.i_col = 4'd0;
`ifdef MOVE_COMMIT_UNDO_EN
    bus.i_undo = 1'b0;
`endif
    model_clear();
    mwin = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_board("rst_board", bus.o_board, mb);
    chk("rst_turn", bus.o_turn, 0);
    chk("rst_count", bus.o_move_count, 0);
    chk("rst_over", bus.o_game_over, 0);
    chk("rst_winner", bus.o_winner, 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_valid", bus.o_result_valid, 0);
    chk("rst_ready", bus.o_move_ready, 1);
    rst = 1'b0;

    issue(7, 7, 0);
    chk("cell112", bus.o_board[2*112 +: 2], 0);
    issue(7, 7, 1);
    chk("dup_count", bus.o_move_count, 1);
    chk("dup_turn", bus.o_turn, 1);

    new_game();
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) issue(0, k / 2, $urandom_range(0, 2));
      else issue(1, k / 2, $urandom_range(0, 2));
    end
    chk("win_result", last_res, 2);
    chk("win_over", bus.o_game_over, 1);
    chk("win_winner", bus.o_winner, 0);
    issue(5, 5, 0);
    chk("after_win", last_res, 1);

    new_game();
    issue(15, 3, 5);
    issue(2, 15, 0);
    chk("oob_count", bus.o_move_count, 0);

    drive_move(3, 3);
    t = 0;
    while (!bus.o_result_valid && t < 8) begin @(negedge clk); t++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk_board("midresp_board", bus.o_board, mb);
    chk("midresp_valid", bus.o_result_valid, 0);
    chk("midresp_count", bus.o_move_count, 0);

    drive_move(4, 4);
    bus.i_new_game = 1'b1;
    @(negedge clk);
    bus.i_new_game = 1'b0;
    sb.delete();
    model_clear();
    chk("ngcheck_ready", bus.o_move_ready, 1);
    chk("ngcheck_valid", bus.o_result_valid, 0);
    chk_board("ngcheck_board", bus.o_board, mb);
    repeat (3) begin
      @(negedge clk);
      chk("ngcheck_quiet", bus.o_result_valid, 0);
    end

`ifdef MOVE_COMMIT_UNDO_EN
    drive_undo(); finish_resp(0);
    issue(6, 6, 0);
    drive_undo(); finish_resp(1);
    chk("undo_cell", bus.o_board[2*96 +: 2], 2);
    chk("undo_count", bus.o_move_count, 0);
    drive_undo(); finish_resp(0);
    chk("undo_twice", last_res, 1);
`endif

    new_game();
    win_en = 1'b0;
    for (int k = 0; k < NCELL; k++) order[k] = k;
    for (int k = NCELL - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      t = order[k]; order[k] = order[j]; order[j] = t;
    end
    for (int k = 0; k < NCELL; k++) issue(order[k] / NC, order[k] % NC, 0);
    chk("draw_result", last_res, 3);
    chk("draw_count", bus.o_move_count, NCELL);
    issue(0, 0, 0);
    chk("full_count", bus.o_move_count, NCELL);
    win_en = 1'b1;

    for (int g = 0; g < 4; g++) begin
      new_game();
      for (int m = 0; m < 70; m++) begin
        sel = $urandom_range(0, 19);
        r = $urandom_range(0, 7);
        c = $urandom_range(0, 7);
        if (sel == 19) r = $urandom_range(13, 15);
        if (sel == 18) c = $urandom_range(13, 15);
`ifdef MOVE_COMMIT_UNDO_EN
        if (sel < 2) begin
          drive_undo();
          finish_resp($urandom_range(0, 3));
        end else
`endif
        issue(r, c, $urandom_range(0, 3));
      end
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
